// File: rtl/reg_rename_file_pkg.sv
// Shared widths, index/tag/word types and the registered operand packet
// for the rename register file.
package reg_rename_file_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ROB_TAG_W = 4;
    localparam int unsigned NREG      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef logic [XLEN-1:0]      xword_t;
    typedef logic [ROB_TAG_W-1:0] rob_tag_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = REG_IDX_W'(0);
    localparam logic     TRUE     = 1'b1;
    localparam logic     FALSE    = 1'b0;

    // Operand packet handed to the reservation station one cycle after issue
    typedef struct packed {
        logic     valid;
        xword_t   data1;
        logic     busy1;
        rob_tag_t tag1;
        xword_t   data2;
        logic     busy2;
        rob_tag_t tag2;
        reg_idx_t rd;
        rob_tag_t tag;
        xword_t   imm;
        xword_t   pc;
    } rs_pkt_t;

endpackage

// File: rtl/reg_rename_file_if.sv
// Decoder / ROB / reservation-station signal bundle around the rename file.
interface reg_rename_file_if;
    import reg_rename_file_pkg::*;

    logic     is_empty_from_dc;
    reg_idx_t rd_from_dc;
    reg_idx_t rs1_from_dc;
    reg_idx_t rs2_from_dc;
    xword_t   imm_from_dc;
    xword_t   pc_from_dc;

    rob_tag_t tag_from_rob;
    logic     is_stall_from_rob;
    logic     is_commit_from_rob;
    reg_idx_t rd_commit_from_rob;
    rob_tag_t tag_commit_from_rob;
    xword_t   data_commit_from_rob;
    logic     is_exception_from_rob;

    logic     is_stall_to_dc;
    logic     is_valid_to_rs;
    xword_t   data1_to_rs;
    logic     busy1_to_rs;
    rob_tag_t tag1_to_rs;
    xword_t   data2_to_rs;
    logic     busy2_to_rs;
    rob_tag_t tag2_to_rs;
    reg_idx_t rd_to_rs;
    rob_tag_t tag_to_rs;
    xword_t   imm_to_rs;
    xword_t   pc_to_rs;

    modport master (
        output is_empty_from_dc, rd_from_dc, rs1_from_dc, rs2_from_dc,
               imm_from_dc, pc_from_dc, tag_from_rob, is_stall_from_rob,
               is_commit_from_rob, rd_commit_from_rob, tag_commit_from_rob,
               data_commit_from_rob, is_exception_from_rob,
        input  is_stall_to_dc, is_valid_to_rs, data1_to_rs, busy1_to_rs,
               tag1_to_rs, data2_to_rs, busy2_to_rs, tag2_to_rs, rd_to_rs,
               tag_to_rs, imm_to_rs, pc_to_rs
    );

    modport slave (
        input  is_empty_from_dc, rd_from_dc, rs1_from_dc, rs2_from_dc,
               imm_from_dc, pc_from_dc, tag_from_rob, is_stall_from_rob,
               is_commit_from_rob, rd_commit_from_rob, tag_commit_from_rob,
               data_commit_from_rob, is_exception_from_rob,
        output is_stall_to_dc, is_valid_to_rs, data1_to_rs, busy1_to_rs,
               tag1_to_rs, data2_to_rs, busy2_to_rs, tag2_to_rs, rd_to_rs,
               tag_to_rs, imm_to_rs, pc_to_rs
    );

endinterface

// File: rtl/reg_rename_file_lookup.sv
// Per-source operand lookup: zero register, same-cycle commit bypass,
// pending producer tag, or architectural value.
module reg_rename_file_lookup
    import reg_rename_file_pkg::*;
(
    input  reg_idx_t src,
    input  xword_t   value,
    input  logic     busy,
    input  rob_tag_t tag,
    input  logic     commit_valid,
    input  rob_tag_t commit_tag,
    input  xword_t   commit_data,
    output xword_t   data,
    output logic     pending,
    output rob_tag_t producer
);

    always_comb begin
        data     = value;
        pending  = busy;
        producer = tag;
        if (src == ZERO_REG) begin
            data     = '0;
            pending  = FALSE;
            producer = '0;
        end else if (busy && commit_valid && (commit_tag == tag)) begin
            // Producer retires this very cycle: forward its value
            data    = commit_data;
            pending = FALSE;
        end
    end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register busy/ROB-tag rename state;
// renames rd at issue, retires at commit, clears renames on exception.
module reg_rename_file
    import reg_rename_file_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    reg_rename_file_if.slave bus
);

    xword_t          value_q [NREG];
    rob_tag_t        tag_q   [NREG];
    logic [NREG-1:0] busy_q;
    rs_pkt_t         pkt_q;

    logic     issue;
    xword_t   src1_data,  src2_data;
    logic     src1_busy,  src2_busy;
    rob_tag_t src1_tag,   src2_tag;

    assign issue = !bus.is_empty_from_dc && !bus.is_stall_from_rob
                   && !bus.is_exception_from_rob;

    assign bus.is_stall_to_dc = bus.is_stall_from_rob | bus.is_exception_from_rob;

    // Lookups see the pre-issue state, so rs==rd reads the older mapping
    reg_rename_file_lookup u_lookup1 (
        .src          (bus.rs1_from_dc),
        .value        (value_q[bus.rs1_from_dc]),
        .busy         (busy_q[bus.rs1_from_dc]),
        .tag          (tag_q[bus.rs1_from_dc]),
        .commit_valid (bus.is_commit_from_rob),
        .commit_tag   (bus.tag_commit_from_rob),
        .commit_data  (bus.data_commit_from_rob),
        .data         (src1_data),
        .pending      (src1_busy),
        .producer     (src1_tag)
    );

    reg_rename_file_lookup u_lookup2 (
        .src          (bus.rs2_from_dc),
        .value        (value_q[bus.rs2_from_dc]),
        .busy         (busy_q[bus.rs2_from_dc]),
        .tag          (tag_q[bus.rs2_from_dc]),
        .commit_valid (bus.is_commit_from_rob),
        .commit_tag   (bus.tag_commit_from_rob),
        .commit_data  (bus.data_commit_from_rob),
        .data         (src2_data),
        .pending      (src2_busy),
        .producer     (src2_tag)
    );

    // Later assignments win: exception clears busy, then rename sets it
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_q  <= '0;
            busy_q <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            pkt_q.valid <= issue;
            if (issue) begin
                pkt_q.data1 <= src1_data;
                pkt_q.busy1 <= src1_busy;
                pkt_q.tag1  <= src1_tag;
                pkt_q.data2 <= src2_data;
                pkt_q.busy2 <= src2_busy;
                pkt_q.tag2  <= src2_tag;
                pkt_q.rd    <= bus.rd_from_dc;
                pkt_q.tag   <= bus.tag_from_rob;
                pkt_q.imm   <= bus.imm_from_dc;
                pkt_q.pc    <= bus.pc_from_dc;
            end
            if (bus.is_commit_from_rob && (bus.rd_commit_from_rob != ZERO_REG)) begin
                value_q[bus.rd_commit_from_rob] <= bus.data_commit_from_rob;
                if (tag_q[bus.rd_commit_from_rob] == bus.tag_commit_from_rob)
                    busy_q[bus.rd_commit_from_rob] <= FALSE;
            end
            if (bus.is_exception_from_rob)
                busy_q <= '0;
            if (issue && (bus.rd_from_dc != ZERO_REG)) begin
                busy_q[bus.rd_from_dc] <= TRUE;
                tag_q[bus.rd_from_dc]  <= bus.tag_from_rob;
            end
        end
    end

    assign bus.is_valid_to_rs = pkt_q.valid;
    assign bus.data1_to_rs    = pkt_q.data1;
    assign bus.busy1_to_rs    = pkt_q.busy1;
    assign bus.tag1_to_rs     = pkt_q.tag1;
    assign bus.data2_to_rs    = pkt_q.data2;
    assign bus.busy2_to_rs    = pkt_q.busy2;
    assign bus.tag2_to_rs     = pkt_q.tag2;
    assign bus.rd_to_rs       = pkt_q.rd;
    assign bus.tag_to_rs      = pkt_q.tag;
    assign bus.imm_to_rs      = pkt_q.imm;
    assign bus.pc_to_rs       = pkt_q.pc;

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: rename, commit, bypass, exception,
// stall and rdy freeze scenarios with hand-computed expectations.
module tb_reg_rename_file;
    import reg_rename_file_pkg::*;

    logic clk;
    logic rst;
    logic rdy;
    int   n_cmp;
    int   n_err;

    reg_rename_file_if bus ();

    reg_rename_file dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.is_empty_from_dc      = 1'b1;
        bus.rd_from_dc            = '0;
        bus.rs1_from_dc           = '0;
        bus.rs2_from_dc           = '0;
        bus.imm_from_dc           = '0;
        bus.pc_from_dc            = '0;
        bus.tag_from_rob          = '0;
        bus.is_stall_from_rob     = 1'b0;
        bus.is_commit_from_rob    = 1'b0;
        bus.rd_commit_from_rob    = '0;
        bus.tag_commit_from_rob   = '0;
        bus.data_commit_from_rob  = '0;
        bus.is_exception_from_rob = 1'b0;
    endtask

    task automatic issue(input reg_idx_t rd, input reg_idx_t rs1, input reg_idx_t rs2,
                         input rob_tag_t tag, input xword_t imm, input xword_t pc);
        bus.is_empty_from_dc = 1'b0;
        bus.rd_from_dc       = rd;
        bus.rs1_from_dc      = rs1;
        bus.rs2_from_dc      = rs2;
        bus.tag_from_rob     = tag;
        bus.imm_from_dc      = imm;
        bus.pc_from_dc       = pc;
    endtask

    task automatic commit(input reg_idx_t rd, input rob_tag_t tag, input xword_t data);
        bus.is_commit_from_rob   = 1'b1;
        bus.rd_commit_from_rob   = rd;
        bus.tag_commit_from_rob  = tag;
        bus.data_commit_from_rob = data;
    endtask

    task automatic test_reset();
        idle();
        issue(5'd3, 5'd1, 5'd2, 4'd7, 32'hFFFF_0000, 32'h0000_0400);
        rdy = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        idle();
        n_cmp++;
        if (bus.is_valid_to_rs !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", bus.is_valid_to_rs);
        end
        n_cmp++;
        if (bus.pc_to_rs !== 32'h0 || bus.imm_to_rs !== 32'h0 || bus.tag_to_rs !== 4'h0) begin
            n_err++; $display("FAIL reset_pkt: pc %h imm %h tag %h want 0", bus.pc_to_rs, bus.imm_to_rs, bus.tag_to_rs);
        end
        n_cmp++;
        if (bus.is_stall_to_dc !== 1'b0) begin
            n_err++; $display("FAIL reset_stall: got %b want 0", bus.is_stall_to_dc);
        end
    endtask

    task automatic test_zero_regs();
        issue(5'd0, 5'd0, 5'd0, 4'd1, 32'h11, 32'h100);
        tick();
        idle();
        n_cmp++;
        if (bus.is_valid_to_rs !== 1'b1 || bus.data1_to_rs !== 32'h0 || bus.busy1_to_rs !== 1'b0
            || bus.data2_to_rs !== 32'h0 || bus.busy2_to_rs !== 1'b0) begin
            n_err++; $display("FAIL zero_ops: valid %b d1 %h b1 %b d2 %h b2 %b want 1 0 0 0 0",
                              bus.is_valid_to_rs, bus.data1_to_rs, bus.busy1_to_rs, bus.data2_to_rs, bus.busy2_to_rs);
        end
        n_cmp++;
        if (bus.imm_to_rs !== 32'h11 || bus.pc_to_rs !== 32'h100 || bus.rd_to_rs !== 5'd0 || bus.tag_to_rs !== 4'd1) begin
            n_err++; $display("FAIL zero_pkt: imm %h pc %h rd %0d tag %0d want 11 100 0 1",
                              bus.imm_to_rs, bus.pc_to_rs, bus.rd_to_rs, bus.tag_to_rs);
        end
        tick();
        n_cmp++;
        if (bus.is_valid_to_rs !== 1'b0) begin
            n_err++; $display("FAIL empty_valid: got %b want 0", bus.is_valid_to_rs);
        end
    endtask

    task automatic test_rename_commit();
        issue(5'd5, 5'd0, 5'd0, 4'd3, 32'h0, 32'h104);
        tick();
        issue(5'd0, 5'd5, 5'd0, 4'd6, 32'h0, 32'h108);
        tick();
        idle();
        n_cmp++;
        if (bus.busy1_to_rs !== 1'b1 || bus.tag1_to_rs !== 4'd3) begin
            n_err++; $display("FAIL rename_busy: busy %b tag %0d want 1 3", bus.busy1_to_rs, bus.tag1_to_rs);
        end
        commit(5'd5, 4'd3, 32'hDEAD_BEEF);
        tick();
        idle();
        issue(5'd0, 5'd5, 5'd0, 4'd6, 32'h0, 32'h10C);
        tick();
        idle();
        n_cmp++;
        if (bus.data1_to_rs !== 32'hDEAD_BEEF || bus.busy1_to_rs !== 1'b0) begin
            n_err++; $display("FAIL commit_read: data %h busy %b want deadbeef 0", bus.data1_to_rs, bus.busy1_to_rs);
        end
    endtask

    task automatic test_commit_bypass();
        issue(5'd7, 5'd0, 5'd0, 4'd2, 32'h0, 32'h110);
        tick();
        idle();
        commit(5'd7, 4'd2, 32'h1234);
        issue(5'd0, 5'd5, 5'd7, 4'd9, 32'h0, 32'h114);
        tick();
        idle();
        n_cmp++;
        if (bus.data2_to_rs !== 32'h1234 || bus.busy2_to_rs !== 1'b0 || bus.data1_to_rs !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL bypass: d2 %h b2 %b d1 %h want 1234 0 deadbeef",
                              bus.data2_to_rs, bus.busy2_to_rs, bus.data1_to_rs);
        end
    endtask

    task automatic test_rename_wins();
        issue(5'd8, 5'd0, 5'd0, 4'd1, 32'h0, 32'h120);
        tick();
        issue(5'd8, 5'd0, 5'd0, 4'd4, 32'h0, 32'h124);
        tick();
        idle();
        commit(5'd8, 4'd1, 32'd9);
        tick();
        idle();
        issue(5'd0, 5'd0, 5'd8, 4'd0, 32'h0, 32'h128);
        tick();
        idle();
        n_cmp++;
        if (bus.busy2_to_rs !== 1'b1 || bus.tag2_to_rs !== 4'd4) begin
            n_err++; $display("FAIL stale_commit: busy %b tag %0d want 1 4", bus.busy2_to_rs, bus.tag2_to_rs);
        end
        // Commit and rename of x9 in the same cycle: reader bypasses, rename survives
        issue(5'd9, 5'd0, 5'd0, 4'd5, 32'h0, 32'h12C);
        tick();
        idle();
        commit(5'd9, 4'd5, 32'h77);
        issue(5'd9, 5'd9, 5'd0, 4'd6, 32'h0, 32'h130);
        tick();
        idle();
        n_cmp++;
        if (bus.data1_to_rs !== 32'h77 || bus.busy1_to_rs !== 1'b0) begin
            n_err++; $display("FAIL same_cycle_read: data %h busy %b want 77 0", bus.data1_to_rs, bus.busy1_to_rs);
        end
        issue(5'd0, 5'd9, 5'd0, 4'd0, 32'h0, 32'h134);
        tick();
        idle();
        n_cmp++;
        if (bus.busy1_to_rs !== 1'b1 || bus.tag1_to_rs !== 4'd6) begin
            n_err++; $display("FAIL same_cycle_rename: busy %b tag %0d want 1 6", bus.busy1_to_rs, bus.tag1_to_rs);
        end
    endtask

    task automatic test_self_dep();
        issue(5'd10, 5'd0, 5'd0, 4'd7, 32'h0, 32'h140);
        tick();
        idle();
        commit(5'd10, 4'd7, 32'h55);
        tick();
        idle();
        issue(5'd10, 5'd10, 5'd0, 4'd8, 32'h0, 32'h144);
        tick();
        idle();
        n_cmp++;
        if (bus.data1_to_rs !== 32'h55 || bus.busy1_to_rs !== 1'b0) begin
            n_err++; $display("FAIL self_dep: data %h busy %b want 55 0", bus.data1_to_rs, bus.busy1_to_rs);
        end
        issue(5'd0, 5'd10, 5'd0, 4'd0, 32'h0, 32'h148);
        tick();
        idle();
        n_cmp++;
        if (bus.busy1_to_rs !== 1'b1 || bus.tag1_to_rs !== 4'd8) begin
            n_err++; $display("FAIL self_rename: busy %b tag %0d want 1 8", bus.busy1_to_rs, bus.tag1_to_rs);
        end
    endtask

    task automatic test_exception();
        // x8 (tag 4), x9 (tag 6), x10 (tag 8) are pending here
        issue(5'd11, 5'd8, 5'd9, 4'd12, 32'h0, 32'h150);
        commit(5'd12, 4'd3, 32'h00C0_FFEE);
        bus.is_exception_from_rob = 1'b1;
        #1;
        n_cmp++;
        if (bus.is_stall_to_dc !== 1'b1) begin
            n_err++; $display("FAIL exc_stall: got %b want 1", bus.is_stall_to_dc);
        end
        tick();
        idle();
        n_cmp++;
        if (bus.is_valid_to_rs !== 1'b0) begin
            n_err++; $display("FAIL exc_valid: got %b want 0", bus.is_valid_to_rs);
        end
        issue(5'd0, 5'd8, 5'd9, 4'd0, 32'h0, 32'h154);
        tick();
        idle();
        n_cmp++;
        if (bus.data1_to_rs !== 32'd9 || bus.busy1_to_rs !== 1'b0 || bus.data2_to_rs !== 32'h77 || bus.busy2_to_rs !== 1'b0) begin
            n_err++; $display("FAIL exc_flush_a: d1 %h b1 %b d2 %h b2 %b want 9 0 77 0",
                              bus.data1_to_rs, bus.busy1_to_rs, bus.data2_to_rs, bus.busy2_to_rs);
        end
        issue(5'd0, 5'd10, 5'd12, 4'd0, 32'h0, 32'h158);
        tick();
        idle();
        n_cmp++;
        if (bus.data1_to_rs !== 32'h55 || bus.busy1_to_rs !== 1'b0 || bus.data2_to_rs !== 32'h00C0_FFEE) begin
            n_err++; $display("FAIL exc_flush_b: d1 %h b1 %b d2 %h want 55 0 c0ffee",
                              bus.data1_to_rs, bus.busy1_to_rs, bus.data2_to_rs);
        end
        issue(5'd0, 5'd11, 5'd0, 4'd0, 32'h0, 32'h15C);
        tick();
        idle();
        n_cmp++;
        if (bus.busy1_to_rs !== 1'b0) begin
            n_err++; $display("FAIL exc_no_rename: busy %b want 0", bus.busy1_to_rs);
        end
    endtask

    task automatic test_stall();
        issue(5'd13, 5'd0, 5'd0, 4'd11, 32'h0, 32'h160);
        bus.is_stall_from_rob = 1'b1;
        #1;
        n_cmp++;
        if (bus.is_stall_to_dc !== 1'b1) begin
            n_err++; $display("FAIL stall_out: got %b want 1", bus.is_stall_to_dc);
        end
        tick();
        idle();
        n_cmp++;
        if (bus.is_valid_to_rs !== 1'b0) begin
            n_err++; $display("FAIL stall_valid: got %b want 0", bus.is_valid_to_rs);
        end
        issue(5'd0, 5'd13, 5'd0, 4'd0, 32'h0, 32'h164);
        tick();
        idle();
        n_cmp++;
        if (bus.busy1_to_rs !== 1'b0 || bus.is_valid_to_rs !== 1'b1) begin
            n_err++; $display("FAIL stall_no_rename: busy %b valid %b want 0 1", bus.busy1_to_rs, bus.is_valid_to_rs);
        end
    endtask

    task automatic test_rdy_freeze();
        issue(5'd14, 5'd7, 5'd0, 4'd10, 32'hAA, 32'h200);
        tick();
        idle();
        rdy = 1'b0;
        issue(5'd15, 5'd14, 5'd0, 4'd11, 32'hBB, 32'h204);
        commit(5'd7, 4'd0, 32'hFFFF);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (bus.is_valid_to_rs !== 1'b1 || bus.data1_to_rs !== 32'h1234 || bus.rd_to_rs !== 5'd14
                || bus.pc_to_rs !== 32'h200 || bus.imm_to_rs !== 32'hAA) begin
                n_err++; $display("FAIL rdy_hold[%0d]: valid %b d1 %h rd %0d pc %h imm %h want 1 1234 14 200 aa",
                                  c, bus.is_valid_to_rs, bus.data1_to_rs, bus.rd_to_rs, bus.pc_to_rs, bus.imm_to_rs);
            end
        end
        rdy = 1'b1;
        idle();
        issue(5'd0, 5'd14, 5'd7, 4'd0, 32'h0, 32'h208);
        tick();
        idle();
        n_cmp++;
        if (bus.busy1_to_rs !== 1'b1 || bus.tag1_to_rs !== 4'd10 || bus.data2_to_rs !== 32'h1234 || bus.busy2_to_rs !== 1'b0) begin
            n_err++; $display("FAIL rdy_resume: b1 %b t1 %0d d2 %h b2 %b want 1 10 1234 0",
                              bus.busy1_to_rs, bus.tag1_to_rs, bus.data2_to_rs, bus.busy2_to_rs);
        end
        issue(5'd0, 5'd15, 5'd0, 4'd0, 32'h0, 32'h20C);
        tick();
        idle();
        n_cmp++;
        if (bus.busy1_to_rs !== 1'b0) begin
            n_err++; $display("FAIL rdy_no_rename: busy %b want 0", bus.busy1_to_rs);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        rdy   = 1'b1;
        idle();
        test_reset();
        test_zero_regs();
        test_rename_commit();
        test_commit_bypass();
        test_rename_wins();
        test_self_dep();
        test_exception();
        test_stall();
        test_rdy_freeze();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- Architectural register file plus per-register rename status (busy bit, ROB tag) for the out-of-order core.
- Sits directly downstream of the decoder:
  - consumes the decoded operand fields (rd, rs1, rs2, imm, pc, empty flag);
  - produces a registered operand packet for the reservation station;
  - takes commit and exception traffic from the ROB.
- Renames rd at issue; retires values at commit.

Parameters:
- ROB_TAG_W, 4, width of ROB entry tag.
- XLEN, 32, data/pc/imm width.
- NREG, 32, number of architectural registers; register 0 is hardwired zero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state and outputs
- is_empty_from_dc  in  1  high = no instruction this cycle
- rd_from_dc  in  5  destination register
- rs1_from_dc  in  5  source 1
- rs2_from_dc  in  5  source 2
- imm_from_dc  in  XLEN  immediate
- pc_from_dc  in  XLEN  instruction pc
- tag_from_rob  in  ROB_TAG_W  ROB entry allocated to the current instruction
- is_stall_from_rob  in  1  ROB/RS full; no issue this cycle
- is_commit_from_rob  in  1  commit valid
- rd_commit_from_rob  in  5  committing rd
- tag_commit_from_rob  in  ROB_TAG_W  committing ROB tag
- data_commit_from_rob  in  XLEN  committing value
- is_exception_from_rob  in  1  flush (mispredict/exception)
- is_stall_to_dc  out  1  backpressure to decoder/queue
- is_valid_to_rs  out  1  operand packet valid
- data1_to_rs  out  XLEN  rs1 value (meaningful when not busy)
- busy1_to_rs  out  1  rs1 awaits tag1_to_rs
- tag1_to_rs  out  ROB_TAG_W  producer tag of rs1
- data2_to_rs  out  XLEN  rs2 value
- busy2_to_rs  out  1  rs2 awaits tag2_to_rs
- tag2_to_rs  out  ROB_TAG_W  producer tag of rs2
- rd_to_rs  out  5  registered rd
- tag_to_rs  out  ROB_TAG_W  registered own tag
- imm_to_rs  out  XLEN  registered imm
- pc_to_rs  out  XLEN  registered pc

Behaviour:
- State per register: value[XLEN], busy, tag[ROB_TAG_W].
- Reset (rst high at posedge):
  - all values 0, all busy 0, all tags 0;
  - is_valid_to_rs 0; all packet outputs 0.
- rdy low: no state change, outputs hold; rst has priority over rdy.
- Issue condition: is_empty_from_dc==0 && is_stall_from_rob==0 && is_exception_from_rob==0.
- is_stall_to_dc = is_stall_from_rob | is_exception_from_rob (combinational).
- Latency: 1 cycle. Packet for an issue at edge N is valid after edge N; is_valid_to_rs is 0 on any non-issuing cycle.
- Operand lookup uses the pre-issue rename state, so an instruction never depends on itself (rs1==rd reads the older mapping).
- Per source s, lookup order:
  1. s==0 -> data 0, busy 0.
  2. Else if busy[s] && same-cycle commit with tag_commit_from_rob==tag[s] -> data=data_commit_from_rob, busy 0 (commit bypass).
  3. Else if busy[s] -> busy 1, tag=tag[s].
  4. Else -> data=value[s], busy 0.
- Commit (is_commit_from_rob && rd_commit!=0):
  - value[rd_commit] <= data_commit, always;
  - busy[rd_commit] cleared only if tag[rd_commit]==tag_commit_from_rob.
- Rename at issue with rd!=0: busy[rd] <= 1, tag[rd] <= tag_from_rob.
- Same-cycle commit and rename to the same rd: value written, busy stays 1, tag becomes the new tag (rename wins).
- Exception: all busy cleared, values kept, packet valid 0. A commit in the same cycle is still written to value.
- Writes to register 0 are ignored in every case.

Decomposition:
- Shared package/header (alongside existing defines):
  - XLEN, ROB_TAG_W, NREG, register index width 5;
  - zero-register constant;
  - True/False.
- No submodule needed.
- Optional sub-module reg_lookup: combinational per-source lookup with bypass, instantiated twice.

Test Plan:
- Reset, then issue rs1=0, rs2=0 -> next cycle valid=1, data1=data2=0, busy1=busy2=0.
- Issue rd=5, tag=3; then issue rs1=5 -> busy1=1, tag1=3. Then commit rd=5, tag=3, data=0xDEADBEEF; re-read x5 -> data1=0xDEADBEEF, busy1=0.
- x7 busy with tag 2. Same cycle: commit tag 2, data=0x1234 and issue rs2=7 -> data2=0x1234, busy2=0.
- Rename x8 tag1, then x8 tag4; commit x8 tag1, data=9 -> value[8]=9 but busy[8]=1, tag=4; later reader sees busy2=1, tag2=4.
- Issue rd=rs1=10 with x10=0x55 not busy -> data1=0x55, busy1=0; afterwards busy[10]=1.
- Three renames pending, then is_exception_from_rob=1 -> valid=0, is_stall_to_dc=1; next read of those regs -> busy=0, old values returned.
- rdy=0 for 3 cycles during issue -> outputs and state frozen, resume identically.
